// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined adder.
//   slice_width : bits handled per pipeline stage
//   cfg_ok      : legal BUS_WIDTH/STAGES combination
//   stage_ctl_t : per-stage control travelling with each beat
package pipelined_adder_pkg;

  typedef struct packed {
    logic valid;
    logic sub;
  } stage_ctl_t;

  function automatic int unsigned slice_width(input int unsigned bus_width,
                                              input int unsigned stages);
    return bus_width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned bus_width,
                                input int unsigned stages);
    return (stages >= 1) && (stages <= bus_width) && ((bus_width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One W-bit ripple slice of the pipelined adder (purely combinational).
//   i_a, i_b  : operand slices
//   i_c       : carry into bit 0
//   o_sum_c   : slice sum
//   o_cout_c  : carry out of the slice MSB
//   o_cmsb_c  : carry into the slice MSB (for signed overflow)
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum_c,
  output logic         o_cout_c,
  output logic         o_cmsb_c
);

  logic [W:0] w_full;

  assign w_full   = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(i_c);
  assign o_sum_c  = w_full[W-1:0];
  assign o_cout_c = w_full[W];
  // The MSB sum bit is a^b^cin, so the carry into it falls out by XOR.
  assign o_cmsb_c = w_full[W-1] ^ i_a[W-1] ^ i_b[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: BUS_WIDTH operands split into STAGES slices,
// one slice per clock, carry registered between slices. Latency STAGES,
// throughput one beat per cycle, valid/ready with backpressure.
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : operand handshake (in_ready is combinational)
//   in1, in2, cin, sub     : operands, carry/borrow in, 0=add 1=sub
//   out_valid/out_ready    : result handshake
//   out, cout, ovf         : result, carry (sub: 1 = no borrow), signed overflow
// Optional: define PIPELINED_ADDER_SAT_EN to clamp out to the signed rail
// on overflow (ovf and cout still report the raw result).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 cout,
  output logic                 ovf
);

  localparam int unsigned SW  = slice_width(BUS_WIDTH, STAGES);
  localparam int unsigned MSB = BUS_WIDTH - 1;
  localparam logic [BUS_WIDTH-1:0] SLICE_MASK = (BUS_WIDTH'(1) << SW) - BUS_WIDTH'(1);

  if (!cfg_ok(BUS_WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: BUS_WIDTH must be a multiple of STAGES");
  end

  // Stage inputs (combinational), stage outputs, and the stage registers.
  logic [BUS_WIDTH-1:0] w_a       [STAGES];
  logic [BUS_WIDTH-1:0] w_b       [STAGES];
  logic [BUS_WIDTH-1:0] w_sum_in  [STAGES];
  logic                 w_cin     [STAGES];
  stage_ctl_t           w_ctl     [STAGES];
  logic [SW-1:0]        w_s       [STAGES];
  logic                 w_co      [STAGES];
  logic                 w_cmsb    [STAGES];
  logic [BUS_WIDTH-1:0] w_sum_out [STAGES];

  logic [BUS_WIDTH-1:0] r_a   [STAGES];
  logic [BUS_WIDTH-1:0] r_b   [STAGES];
  logic [BUS_WIDTH-1:0] r_sum [STAGES];
  logic                 r_c   [STAGES];
  stage_ctl_t           r_ctl [STAGES];
  logic                 r_ovf;

  logic                 w_adv;
  logic                 w_ovf;
  logic [BUS_WIDTH-1:0] w_res;

  // Whole pipeline moves together whenever the output slot can be vacated.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction as A + ~B + ~borrow.
      assign w_a[k]      = in1;
      assign w_b[k]      = in2 ^ {BUS_WIDTH{sub}};
      assign w_sum_in[k] = '0;
      assign w_cin[k]    = cin ^ sub;
      assign w_ctl[k]    = {in_valid, sub};
    end else begin : g_body
      assign w_a[k]      = r_a[k-1];
      assign w_b[k]      = r_b[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_cin[k]    = r_c[k-1];
      assign w_ctl[k]    = r_ctl[k-1];
    end

    adder_slice #(.W(SW)) u_slice (
      .i_a      (w_a[k][k*SW +: SW]),
      .i_b      (w_b[k][k*SW +: SW]),
      .i_c      (w_cin[k]),
      .o_sum_c  (w_s[k]),
      .o_cout_c (w_co[k]),
      .o_cmsb_c (w_cmsb[k])
    );

    // Merge this slice into the partially built result word.
    assign w_sum_out[k] = (w_sum_in[k] & ~(SLICE_MASK << (k*SW)))
                        | (BUS_WIDTH'(w_s[k]) << (k*SW));
  end

  assign w_ovf = w_cmsb[STAGES-1] ^ w_co[STAGES-1];

`ifdef PIPELINED_ADDER_SAT_EN
  // On overflow both effective operands share a sign; A's MSB picks the rail.
  localparam logic [BUS_WIDTH-1:0] SMIN = BUS_WIDTH'(1) << MSB;
  always_comb begin
    w_res = w_sum_out[STAGES-1];
    if (w_ovf) begin
      w_res = w_a[STAGES-1][MSB] ? SMIN : ~SMIN;
    end
  end
`else
  assign w_res = w_sum_out[STAGES-1];
`endif

  // Stage registers; all hold when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_sum[i] <= '0;
        r_c[i]   <= 1'b0;
        r_ctl[i] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_a[i]   <= w_a[i];
        r_b[i]   <= w_b[i];
        r_sum[i] <= w_sum_out[i];
        r_c[i]   <= w_co[i];
        r_ctl[i] <= w_ctl[i];
      end
      r_sum[STAGES-1] <= w_res;
      r_ovf           <= w_ovf;
    end
  end

  assign out_valid = r_ctl[STAGES-1].valid;
  assign out       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule
